// File: rtl/systolic_feeder_if.sv
// Host-side bundle for the systolic feeder: buffer writes, run
// control and the skewed west/north operand lanes.
interface systolic_feeder_if #(
  parameter int DATA_SIZE = 32,
  parameter int N         = 4,
  parameter int K_MAX     = 16
);
  localparam int IW = $clog2(N);
  localparam int KW = $clog2(K_MAX);

  logic                   wr_en;
  logic                   wr_mat;
  logic [IW-1:0]          wr_idx;
  logic [KW-1:0]          wr_k;
  logic [DATA_SIZE-1:0]   wr_data;
  logic                   start;
  logic [KW:0]            k_len;
  logic                   busy;
  logic                   acc_clr;
  logic [N*DATA_SIZE-1:0] a_out;
  logic [N*DATA_SIZE-1:0] b_out;
  logic                   done;
  logic                   err;

  modport master (
    output wr_en, wr_mat, wr_idx, wr_k, wr_data,
    output start, k_len,
    input  busy, acc_clr, a_out, b_out, done, err
  );

  modport slave (
    input  wr_en, wr_mat, wr_idx, wr_k, wr_data,
    input  start, k_len,
    output busy, acc_clr, a_out, b_out, done, err
  );
endinterface

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N MAC array: buffers A and B, clears
// the accumulators, then streams diagonally skewed lanes.
module systolic_feeder #(
  parameter int DATA_SIZE = 32,
  parameter int N         = 4,
  parameter int K_MAX     = 16
) (
  input logic           clk,
  input logic           rst,
  systolic_feeder_if.slave bus
);
  localparam int KW = $clog2(K_MAX);
  localparam int LW = KW + 1;
  localparam int CW = $clog2(K_MAX + 2 * N) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [CW-1:0]          w_last_beat;
  logic [LW-1:0]          r_k;
  logic                   w_k_ok;
  logic                   w_go;
  logic                   w_err_nxt;
  logic [N*DATA_SIZE-1:0] w_a_nxt;
  logic [N*DATA_SIZE-1:0] w_b_nxt;
  logic [DATA_SIZE-1:0]   r_a [N][K_MAX];
  logic [DATA_SIZE-1:0]   r_b [N][K_MAX];
  logic                   r_busy;
  logic                   r_clr;
  logic                   r_done;
  logic                   r_err;
  logic [N*DATA_SIZE-1:0] r_a_out;
  logic [N*DATA_SIZE-1:0] r_b_out;

  assign w_k_ok = (bus.k_len != '0) &&
                  (bus.k_len <= LW'(K_MAX));
  assign w_go   = (r_state == S_IDLE) && bus.start && w_k_ok;
  assign w_last_beat = CW'(r_k) + CW'(N - 2);

  // B is held column-major so both lanes share one skew lookup.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.wr_en) begin
      if (bus.wr_mat)
        r_b[bus.wr_idx][bus.wr_k] <= bus.wr_data;
      else
        r_a[bus.wr_idx][bus.wr_k] <= bus.wr_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_go)
          w_state_nxt = S_CLEAR;
        else if (bus.start)
          w_err_nxt = 1'b1;
      end
      S_CLEAR: begin
        w_state_nxt = S_FEED;
        w_cnt_nxt   = '0;
      end
      S_FEED: begin
        if (r_cnt == w_last_beat) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (r_cnt == CW'(N - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane l carries inner index (beat - l) while it lies in [0, K).
  always_comb begin
    logic [CW-1:0] off;
    off     = '0;
    w_a_nxt = '0;
    w_b_nxt = '0;
    if (w_state_nxt == S_FEED) begin
      for (int l = 0; l < N; l++) begin
        off = w_cnt_nxt - CW'(l);
        if (w_cnt_nxt >= CW'(l) && off < CW'(r_k)) begin
          w_a_nxt[l*DATA_SIZE +: DATA_SIZE] = r_a[l][off[KW-1:0]];
          w_b_nxt[l*DATA_SIZE +: DATA_SIZE] = r_b[l][off[KW-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_a_out <= '0;
      r_b_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_go)
        r_k <= bus.k_len;
      r_busy  <= (w_state_nxt == S_CLEAR) ||
                 (w_state_nxt == S_FEED) ||
                 (w_state_nxt == S_DRAIN &&
                  w_cnt_nxt != CW'(N - 1));
      r_clr   <= (w_state_nxt == S_CLEAR);
      r_done  <= (w_state_nxt == S_DRAIN) &&
                 (w_cnt_nxt == CW'(N - 1));
      r_err   <= w_err_nxt;
      r_a_out <= w_a_nxt;
      r_b_out <= w_b_nxt;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.acc_clr = r_clr;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.a_out   = r_a_out;
  assign bus.b_out   = r_b_out;
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: random A/B loads, trace vs skew model,
// and a behavioural 4x4 MAC grid fed by the DUT lanes.
module tb_systolic_feeder;
  localparam int DS = 32;
  localparam int N  = 4;
  localparam int KM = 16;
  localparam int LW = $clog2(KM) + 1;
  localparam int TL = KM + 2 * N + 4;

  logic clk = 1'b0;
  logic rst;

  systolic_feeder_if #(.DATA_SIZE(DS), .N(N), .K_MAX(KM)) bus ();

  systolic_feeder #(.DATA_SIZE(DS), .N(N), .K_MAX(KM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int done_at;

  logic [DS-1:0]   mA [N][KM];
  logic [DS-1:0]   mB [KM][N];
  logic [3:0]      tr_ctl [TL];
  logic [N*DS-1:0] tr_a [TL];
  logic [N*DS-1:0] tr_b [TL];
  logic [DS-1:0]   c_snap [N][N];

  // MAC grid: a moves east, b moves south, one register per hop.
  logic [DS-1:0] pa [N][N];
  logic [DS-1:0] pb [N][N];
  logic [DS-1:0] acc [N][N];

  always @(posedge clk) begin
    logic [DS-1:0] ai, bi;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int im, jm;
        im = (i > 0) ? i - 1 : 0;
        jm = (j > 0) ? j - 1 : 0;
        ai = (j == 0) ? bus.a_out[i*DS +: DS] : pa[i][jm];
        bi = (i == 0) ? bus.b_out[j*DS +: DS] : pb[im][j];
        pa[i][j]  <= ai;
        pb[i][j]  <= bi;
        acc[i][j] <= bus.acc_clr ? '0 : acc[i][j] + ai * bi;
      end
    end
  end

  function automatic logic [DS-1:0] exp_lane(
    input bit isb, input int l, input int c, input int k);
    int t;
    t = c - 2 - l;
    if (c < 2 || c - 2 > k + N - 2 || t < 0 || t >= k)
      return '0;
    return isb ? mB[t][l] : mA[l][t];
  endfunction

  function automatic logic [3:0] exp_ctl(input int c, input int k);
    return {(c >= 1 && c <= k + 2 * N - 1), (c == 1),
            (c == k + 2 * N), 1'b0};
  endfunction

  function automatic logic [DS-1:0] exp_c(
    input int i, input int j, input int k);
    logic [DS-1:0] s;
    s = '0;
    for (int x = 0; x < k; x++)
      s = s + mA[i][x] * mB[x][j];
    return s;
  endfunction

  task automatic wr(input bit mat, input int idx, input int k,
                    input logic [DS-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_mat  = mat;
    bus.wr_idx  = 2'(idx);
    bus.wr_k    = 4'(k);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic load(input bit ones);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < KM; k++) begin
        mA[i][k] = ones ? DS'(1) : DS'($urandom);
        mB[k][i] = ones ? DS'(1) : DS'($urandom);
        wr(1'b0, i, k, mA[i][k]);
        wr(1'b1, i, k, mB[k][i]);
      end
    end
  endtask

  // Starts a run and records every cycle; poke > 0 injects a write
  // plus a start on that cycle.
  task automatic capture(input int k, input int poke);
    bus.start = 1'b1;
    bus.k_len = LW'(k);
    done_at   = -1;
    for (int c = 1; c < TL; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      tr_ctl[c] = {bus.busy, bus.acc_clr, bus.done, bus.err};
      tr_a[c]   = bus.a_out;
      tr_b[c]   = bus.b_out;
      if (bus.done && done_at < 0) begin
        done_at = c;
        c_snap  = acc;
      end
      if (c == poke) begin
        bus.wr_en   = 1'b1;
        bus.wr_mat  = 1'b0;
        bus.wr_idx  = '0;
        bus.wr_k    = '0;
        bus.wr_data = ~mA[0][0];
        bus.start   = 1'b1;
        bus.k_len   = LW'(2);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (bus.busy !== 1'b0) begin
      errs++; $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    vecs++;
    if (bus.acc_clr !== 1'b0) begin
      errs++; $display("FAIL reset_clr got %b want 0", bus.acc_clr);
    end
    vecs++;
    if (bus.done !== 1'b0) begin
      errs++; $display("FAIL reset_done got %b want 0", bus.done);
    end
    vecs++;
    if (bus.err !== 1'b0) begin
      errs++; $display("FAIL reset_err got %b want 0", bus.err);
    end
    vecs++;
    if (bus.a_out !== '0 || bus.b_out !== '0) begin
      errs++;
      $display("FAIL reset_lanes a=%h b=%h want 0", bus.a_out, bus.b_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_feed();
    int kv [3];
    kv[0] = 1;
    kv[1] = N;
    kv[2] = $urandom_range(2, KM - 1);
    load(1'b0);
    for (int r = 0; r < 3; r++) begin
      int k;
      k = kv[r];
      capture(k, 0);
      for (int c = 1; c < TL; c++) begin
        logic [N*DS-1:0] ea, eb;
        for (int l = 0; l < N; l++) begin
          ea[l*DS +: DS] = exp_lane(1'b0, l, c, k);
          eb[l*DS +: DS] = exp_lane(1'b1, l, c, k);
        end
        vecs++;
        if (tr_a[c] !== ea || tr_b[c] !== eb ||
            tr_ctl[c] !== exp_ctl(c, k)) begin
          errs++;
          $display("FAIL feed k=%0d c=%0d ctl=%b/%b a=%h/%h b=%h/%h",
                   k, c, tr_ctl[c], exp_ctl(c, k), tr_a[c], ea,
                   tr_b[c], eb);
        end
      end
      vecs++;
      if (done_at != k + 2 * N) begin
        errs++;
        $display("FAIL feed_latency k=%0d got %0d want %0d",
                 k, done_at, k + 2 * N);
      end
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          vecs++;
          if (c_snap[i][j] !== exp_c(i, j, k)) begin
            errs++;
            $display("FAIL mac k=%0d C[%0d][%0d] got %h want %h",
                     k, i, j, c_snap[i][j], exp_c(i, j, k));
          end
        end
      end
    end
  endtask

  task automatic test_wr_with_start();
    logic [DS-1:0] nv;
    nv = DS'($urandom);
    mA[2][0] = nv;
    bus.wr_en   = 1'b1;
    bus.wr_mat  = 1'b0;
    bus.wr_idx  = 2'd2;
    bus.wr_k    = '0;
    bus.wr_data = nv;
    capture(3, 0);
    for (int c = 1; c < TL; c++) begin
      logic [N*DS-1:0] ea, eb;
      for (int l = 0; l < N; l++) begin
        ea[l*DS +: DS] = exp_lane(1'b0, l, c, 3);
        eb[l*DS +: DS] = exp_lane(1'b1, l, c, 3);
      end
      vecs++;
      if (tr_a[c] !== ea || tr_b[c] !== eb ||
          tr_ctl[c] !== exp_ctl(c, 3)) begin
        errs++;
        $display("FAIL wr_start c=%0d ctl=%b/%b a=%h/%h b=%h/%h",
                 c, tr_ctl[c], exp_ctl(c, 3), tr_a[c], ea, tr_b[c], eb);
      end
    end
  endtask

  task automatic test_err();
    int bad [3];
    bad[0] = 0;
    bad[1] = KM + 1;
    bad[2] = (1 << LW) - 1;
    for (int r = 0; r < 3; r++) begin
      bus.start = 1'b1;
      bus.k_len = LW'(bad[r]);
      @(negedge clk);
      bus.start = 1'b0;
      vecs++;
      if ({bus.busy, bus.acc_clr, bus.done, bus.err} !== 4'b0001 ||
          bus.a_out !== '0 || bus.b_out !== '0) begin
        errs++;
        $display("FAIL err_pulse k_len=%0d ctl=%b want 0001 a=%h b=%h",
                 bad[r], {bus.busy, bus.acc_clr, bus.done, bus.err},
                 bus.a_out, bus.b_out);
      end
      @(negedge clk);
      vecs++;
      if ({bus.busy, bus.acc_clr, bus.done, bus.err} !== 4'b0000) begin
        errs++;
        $display("FAIL err_clear k_len=%0d ctl=%b want 0000",
                 bad[r], {bus.busy, bus.acc_clr, bus.done, bus.err});
      end
    end
  endtask

  task automatic test_busy_ignore();
    for (int pass = 0; pass < 2; pass++) begin
      capture(5, (pass == 0) ? 4 : 0);
      for (int c = 1; c < TL; c++) begin
        logic [N*DS-1:0] ea, eb;
        for (int l = 0; l < N; l++) begin
          ea[l*DS +: DS] = exp_lane(1'b0, l, c, 5);
          eb[l*DS +: DS] = exp_lane(1'b1, l, c, 5);
        end
        vecs++;
        if (tr_a[c] !== ea || tr_b[c] !== eb ||
            tr_ctl[c] !== exp_ctl(c, 5)) begin
          errs++;
          $display("FAIL busy_ign p=%0d c=%0d ctl=%b/%b a=%h/%h b=%h/%h",
                   pass, c, tr_ctl[c], exp_ctl(c, 5), tr_a[c], ea,
                   tr_b[c], eb);
        end
      end
    end
  endtask

  task automatic test_kmax();
    int nz;
    load(1'b1);
    capture(KM, 0);
    nz = 0;
    for (int c = 1; c < TL; c++) begin
      logic [N*DS-1:0] ea, eb;
      for (int l = 0; l < N; l++) begin
        ea[l*DS +: DS] = exp_lane(1'b0, l, c, KM);
        eb[l*DS +: DS] = exp_lane(1'b1, l, c, KM);
      end
      if (tr_a[c] != '0) nz++;
      vecs++;
      if (tr_a[c] !== ea || tr_b[c] !== eb ||
          tr_ctl[c] !== exp_ctl(c, KM)) begin
        errs++;
        $display("FAIL kmax c=%0d ctl=%b/%b a=%h/%h b=%h/%h",
                 c, tr_ctl[c], exp_ctl(c, KM), tr_a[c], ea, tr_b[c], eb);
      end
    end
    vecs++;
    if (nz != KM + N - 1) begin
      errs++;
      $display("FAIL kmax_feed_len got %0d want %0d", nz, KM + N - 1);
    end
    vecs++;
    if (done_at != KM + 8) begin
      errs++;
      $display("FAIL kmax_done got %0d want %0d", done_at, KM + 8);
    end
    vecs++;
    if (c_snap[N-1][N-1] !== DS'(KM)) begin
      errs++;
      $display("FAIL kmax_corner got %0d want %0d", c_snap[N-1][N-1], KM);
    end
  endtask

  task automatic test_reset_mid();
    load(1'b0);
    bus.start = 1'b1;
    bus.k_len = LW'(6);
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b0;
    #1;
    vecs++;
    if ({bus.busy, bus.acc_clr, bus.done, bus.err} !== 4'b0000 ||
        bus.a_out !== '0 || bus.b_out !== '0) begin
      errs++;
      $display("FAIL mid_reset ctl=%b a=%h b=%h want 0",
               {bus.busy, bus.acc_clr, bus.done, bus.err},
               bus.a_out, bus.b_out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    capture(6, 0);
    for (int c = 1; c < TL; c++) begin
      logic [N*DS-1:0] ea, eb;
      for (int l = 0; l < N; l++) begin
        ea[l*DS +: DS] = exp_lane(1'b0, l, c, 6);
        eb[l*DS +: DS] = exp_lane(1'b1, l, c, 6);
      end
      vecs++;
      if (tr_a[c] !== ea || tr_b[c] !== eb ||
          tr_ctl[c] !== exp_ctl(c, 6)) begin
        errs++;
        $display("FAIL rerun c=%0d ctl=%b/%b a=%h/%h b=%h/%h",
                 c, tr_ctl[c], exp_ctl(c, 6), tr_a[c], ea, tr_b[c], eb);
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        vecs++;
        if (c_snap[i][j] !== exp_c(i, j, 6)) begin
          errs++;
          $display("FAIL rerun_mac C[%0d][%0d] got %h want %h",
                   i, j, c_snap[i][j], exp_c(i, j, 6));
        end
      end
    end
  endtask

  initial begin
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_mat  = 1'b0;
    bus.wr_idx  = '0;
    bus.wr_k    = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.k_len   = '0;
    test_reset();
    test_feed();
    test_wr_with_start();
    test_err();
    test_busy_ignore();
    test_kmax();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
